mccpu_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS-subset CPU. It replaces the single-cycle combinational decoder with a FETCH/DECODE/EXE/MEM/WB state machine. It drives the PC, IR, register-file, ALU and memory-interface enables of the multi-cycle datapath. Memory accesses complete either on a ready handshake or after a parametrised fixed latency. The block also flags illegal instructions and pulses on every retired instruction.

---
 rtl/mccpu_ctrl_if.sv | 39 +++
 rtl/mccpu_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mccpu_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mccpu_ctrl_if.sv
// Control-unit bus between the multi-cycle controller and its datapath.
//   Inputs to the controller : Op, Funct (IR fields), Zero (ALU flag), mem_ready.
//   Outputs of the controller: PC/IR/register-file/memory enables, ALU and mux
//                              selects, debug state, instr_done and illegal pulses.
// master = controller side, slave = datapath side.
interface mccpu_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       EXTOp;
    logic       ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] NPCOp;
    logic [1:0] GPRSel;
    logic [1:0] WDSel;
    logic [2:0] state;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  Op, Funct, Zero, mem_ready,
        output PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp, ALUSrcB,
               ALUOp, NPCOp, GPRSel, WDSel, state, instr_done, illegal
    );

    modport slave (
        output Op, Funct, Zero, mem_ready,
        input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp, ALUSrcB,
               ALUOp, NPCOp, GPRSel, WDSel, state, instr_done, illegal
    );
endinterface

// File: rtl/mccpu_ctrl.sv
// Multi-cycle control unit for the MIPS-subset CPU (FETCH/DECODE/EXE/MEM/WB).
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - mccpu_ctrl_if.master: IR fields, Zero, mem_ready in; datapath enables,
//         selects, debug state, instr_done and illegal out
// Memory accesses finish on mem_ready (MEM_HANDSHAKE=1) or after MEM_LAT cycles.
module mccpu_ctrl #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned MEM_LAT       = 2
) (
    input  logic         clk,
    input  logic         rst,
    mccpu_ctrl_if.master bus
);
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXE    = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;

    localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_NOR = 4'd7;
    localparam logic [3:0] ALU_LUI = 4'd9;

    localparam int unsigned       CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LAT - 1);

    // Instruction decode
    logic       is_rtype, is_ialu, is_lw, is_sw, is_beq, is_j, is_jal, legal;
    logic [3:0] alu_op;
    logic       alu_src_b, ext_op;

    always_comb begin
        is_rtype  = 1'b0;
        is_ialu   = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_beq    = 1'b0;
        is_j      = 1'b0;
        is_jal    = 1'b0;
        alu_op    = ALU_NOP;
        alu_src_b = 1'b0;
        ext_op    = 1'b0;
        case (bus.Op)
            6'h00: begin
                is_rtype = 1'b1;
                case (bus.Funct)
                    6'h20, 6'h21: alu_op = ALU_ADD;
                    6'h22, 6'h23: alu_op = ALU_SUB;
                    6'h24:        alu_op = ALU_AND;
                    6'h25:        alu_op = ALU_OR;
                    6'h27:        alu_op = ALU_NOR;
                    6'h2A:        alu_op = ALU_SLT;
                    6'h2B:        alu_op = ALU_SLTU;
                    default:      is_rtype = 1'b0;
                endcase
            end
            6'h08: begin is_ialu = 1'b1; alu_op = ALU_ADD; alu_src_b = 1'b1; ext_op = 1'b1; end
            6'h0A: begin is_ialu = 1'b1; alu_op = ALU_SLT; alu_src_b = 1'b1; ext_op = 1'b1; end
            6'h0C: begin is_ialu = 1'b1; alu_op = ALU_AND; alu_src_b = 1'b1; end
            6'h0D: begin is_ialu = 1'b1; alu_op = ALU_OR;  alu_src_b = 1'b1; end
            6'h0F: begin is_ialu = 1'b1; alu_op = ALU_LUI; alu_src_b = 1'b1; end
            6'h23: begin is_lw   = 1'b1; alu_op = ALU_ADD; alu_src_b = 1'b1; ext_op = 1'b1; end
            6'h2B: begin is_sw   = 1'b1; alu_op = ALU_ADD; alu_src_b = 1'b1; ext_op = 1'b1; end
            6'h04: begin is_beq  = 1'b1; alu_op = ALU_SUB; ext_op = 1'b1; end
            6'h02: is_j   = 1'b1;
            6'h03: is_jal = 1'b1;
            default: ;
        endcase
        legal = is_rtype | is_ialu | is_lw | is_sw | is_beq | is_j | is_jal;
    end

    // State and access counter
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_state, mem_done;

    assign mem_state = (state_q == FETCH) || (state_q == MEM);
    assign mem_done  = MEM_HANDSHAKE ? bus.mem_ready : (cnt_q == CNT_LAST);

    // The counter only runs while waiting on memory; any completion or state change restarts it.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (MEM_HANDSHAKE || !mem_state || mem_done || (state_d != state_q)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.state = state_q;

    // Next state and datapath controls
    always_comb begin
        state_d        = state_q;
        bus.PCWrite    = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IorD       = 1'b0;
        bus.EXTOp      = 1'b0;
        bus.ALUSrcB    = 1'b0;
        bus.ALUOp      = ALU_NOP;
        bus.NPCOp      = 2'b00;
        bus.GPRSel     = 2'b00;
        bus.WDSel      = 2'b00;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                bus.MemRead = 1'b1;
                if (mem_done) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    state_d     = DECODE;
                end
            end
            DECODE: begin
                bus.EXTOp = ext_op;
                if (is_j || is_jal) begin
                    bus.PCWrite    = 1'b1;
                    bus.NPCOp      = 2'b10;
                    bus.instr_done = 1'b1;
                    if (is_jal) begin
                        // PC already holds PC+4, which is the link value.
                        bus.RegWrite = 1'b1;
                        bus.GPRSel   = 2'b10;
                        bus.WDSel    = 2'b10;
                    end
                    state_d = FETCH;
                end else if (!legal) begin
                    bus.illegal = 1'b1;
                    state_d     = FETCH;
                end else begin
                    state_d = EXE;
                end
            end
            EXE, MEM, WB: begin
                // ALU controls held through EXE..WB so ALUOut stays stable.
                bus.ALUOp   = alu_op;
                bus.ALUSrcB = alu_src_b;
                bus.EXTOp   = ext_op;
                if (state_q == EXE) begin
                    if (is_beq) begin
                        bus.PCWrite    = bus.Zero;
                        bus.NPCOp      = 2'b01;
                        bus.instr_done = 1'b1;
                        state_d        = FETCH;
                    end else begin
                        state_d = (is_lw || is_sw) ? MEM : WB;
                    end
                end else if (state_q == MEM) begin
                    bus.IorD = 1'b1;
                    if (is_lw) begin
                        bus.MemRead = 1'b1;
                        if (mem_done) state_d = WB;
                    end else if (is_sw) begin
                        bus.MemWrite = 1'b1;
                        if (mem_done) begin
                            bus.instr_done = 1'b1;
                            state_d        = FETCH;
                        end
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                    if (is_lw) begin
                        bus.WDSel  = 2'b01;
                        bus.GPRSel = 2'b01;
                    end else if (is_ialu) begin
                        bus.GPRSel = 2'b01;
                    end
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        // Reset silences every control so an interrupted access cannot write.
        if (rst) begin
            bus.PCWrite    = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.RegWrite   = 1'b0;
            bus.MemRead    = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.IorD       = 1'b0;
            bus.EXTOp      = 1'b0;
            bus.ALUSrcB    = 1'b0;
            bus.ALUOp      = ALU_NOP;
            bus.NPCOp      = 2'b00;
            bus.GPRSel     = 2'b00;
            bus.WDSel      = 2'b00;
            bus.instr_done = 1'b0;
            bus.illegal    = 1'b0;
        end
    end
endmodule

// File: tb/tb_mccpu_ctrl.sv
// Self-checking bench for mccpu_ctrl. Four instances cover fixed latency 2, fixed
// latency 1, handshake mode and fixed latency 4. A reference model expands each
// instruction into its expected per-cycle control pattern from the instruction class.
module tb_mccpu_ctrl;
    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4;
    localparam logic [2:0] CL_ILL = 3'd0, CL_R = 3'd1, CL_I = 3'd2, CL_LW = 3'd3;
    localparam logic [2:0] CL_SW = 3'd4, CL_BEQ = 3'd5, CL_J = 3'd6, CL_JAL = 3'd7;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, irw, rw, mr, mw, iord, ext, srcb;
        logic [3:0] alu;
        logic [1:0] npc, gpr, wd;
        logic       done, ill;
    } vec_t;

    typedef struct packed {
        logic [2:0] cls;
        logic [3:0] alu;
        logic       srcb;
        logic       ext;
    } dec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op_v    [4];
    logic [5:0] funct_v [4];
    logic       zero_v  [4];
    logic       rdy_v   [4];
    vec_t       obs     [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mccpu_ctrl_if bus ();
        assign bus.Op        = op_v[g];
        assign bus.Funct     = funct_v[g];
        assign bus.Zero      = zero_v[g];
        assign bus.mem_ready = rdy_v[g];
        assign obs[g] = {bus.state, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRead,
                         bus.MemWrite, bus.IorD, bus.EXTOp, bus.ALUSrcB, bus.ALUOp, bus.NPCOp,
                         bus.GPRSel, bus.WDSel, bus.instr_done, bus.illegal};
        mccpu_ctrl #(
            .MEM_HANDSHAKE(g == 2),
            .MEM_LAT      ((g == 0) ? 2 : ((g == 3) ? 4 : 1))
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    function automatic bit hs_of(input int k);
        return k == 2;
    endfunction

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            3:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic check_vec(input string tag, input vec_t got, input vec_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Instruction classification straight from the supported-instruction table.
    function automatic dec_t ref_decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d = '0;
        case (op)
            6'h00: begin
                d.cls = CL_R;
                case (fn)
                    6'h20, 6'h21: d.alu = 4'd1;
                    6'h22, 6'h23: d.alu = 4'd2;
                    6'h24:        d.alu = 4'd3;
                    6'h25:        d.alu = 4'd4;
                    6'h27:        d.alu = 4'd7;
                    6'h2A:        d.alu = 4'd5;
                    6'h2B:        d.alu = 4'd6;
                    default:      d.cls = CL_ILL;
                endcase
            end
            6'h08: d = '{cls: CL_I,   alu: 4'd1, srcb: 1'b1, ext: 1'b1};
            6'h0A: d = '{cls: CL_I,   alu: 4'd5, srcb: 1'b1, ext: 1'b1};
            6'h0C: d = '{cls: CL_I,   alu: 4'd3, srcb: 1'b1, ext: 1'b0};
            6'h0D: d = '{cls: CL_I,   alu: 4'd4, srcb: 1'b1, ext: 1'b0};
            6'h0F: d = '{cls: CL_I,   alu: 4'd9, srcb: 1'b1, ext: 1'b0};
            6'h23: d = '{cls: CL_LW,  alu: 4'd1, srcb: 1'b1, ext: 1'b1};
            6'h2B: d = '{cls: CL_SW,  alu: 4'd1, srcb: 1'b1, ext: 1'b1};
            6'h04: d = '{cls: CL_BEQ, alu: 4'd2, srcb: 1'b0, ext: 1'b1};
            6'h02: d.cls = CL_J;
            6'h03: d.cls = CL_JAL;
            default: ;
        endcase
        return d;
    endfunction

    // Called at posedge+1; checks at the falling edge, returns at the next posedge+1.
    task automatic step(input int k, input string tag, input vec_t e, input vec_t m);
        @(negedge clk);
        check_vec(tag, obs[k] & m, e & m);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) check_vec("reset", obs[k], '0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // zexe<0 / fwait<0 / mwait<0 mean random; abort_at>=0 raises rst in that MEM cycle.
    task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn,
                             input int zexe, input int fwait, input int mwait,
                             input int abort_at);
        dec_t d;
        vec_t e, m;
        int   n;
        bit   hs;
        d  = ref_decode(op, fn);
        hs = hs_of(k);

        // FETCH: IR still holds the previous word, so Op/Funct are scrambled here.
        n = hs ? ((fwait < 0) ? int'($urandom_range(0, 3)) : fwait) + 1 : lat_of(k);
        for (int i = 0; i < n; i++) begin
            op_v[k]    = 6'($urandom);
            funct_v[k] = 6'($urandom);
            zero_v[k]  = 1'($urandom);
            rdy_v[k]   = hs ? (i == n - 1) : 1'($urandom);
            e = '0;
            e.st = S_F;
            e.mr = 1'b1;
            if (i == n - 1) begin
                e.irw = 1'b1;
                e.pcw = 1'b1;
            end
            m = '1;
            m.ext = 1'b0; m.srcb = 1'b0; m.alu = '0;
            step(k, "fetch", e, m);
        end

        // DECODE: mem_ready here must be ignored.
        op_v[k]    = op;
        funct_v[k] = fn;
        zero_v[k]  = 1'($urandom);
        rdy_v[k]   = 1'($urandom);
        e = '0;
        e.st  = S_D;
        e.ext = d.ext;
        m = '1;
        m.srcb = 1'b0; m.alu = '0;
        if (d.cls == CL_J || d.cls == CL_JAL) begin
            e.pcw  = 1'b1;
            e.npc  = 2'b10;
            e.done = 1'b1;
            if (d.cls == CL_JAL) begin
                e.rw  = 1'b1;
                e.gpr = 2'b10;
                e.wd  = 2'b10;
            end
        end else if (d.cls == CL_ILL) begin
            e.ill = 1'b1;
        end
        step(k, "decode", e, m);
        if (d.cls == CL_J || d.cls == CL_JAL || d.cls == CL_ILL) return;

        // EXE
        zero_v[k] = (zexe < 0) ? 1'($urandom) : 1'(zexe);
        rdy_v[k]  = 1'($urandom);
        e = '0;
        e.st = S_E; e.alu = d.alu; e.srcb = d.srcb; e.ext = d.ext;
        if (d.cls == CL_BEQ) begin
            e.pcw  = zero_v[k];
            e.npc  = 2'b01;
            e.done = 1'b1;
        end
        m = '1;
        step(k, "exe", e, m);
        if (d.cls == CL_BEQ) return;

        // MEM
        if (d.cls == CL_LW || d.cls == CL_SW) begin
            n = hs ? ((mwait < 0) ? int'($urandom_range(0, 3)) : mwait) + 1 : lat_of(k);
            for (int i = 0; i < n; i++) begin
                zero_v[k] = 1'($urandom);
                rdy_v[k]  = hs ? (i == n - 1) : 1'($urandom);
                if (i == abort_at) begin
                    rst = 1'b1;
                    #1;
                    check_vec("abort", obs[k], '0);
                    return;
                end
                e = '0;
                e.st = S_M; e.alu = d.alu; e.srcb = d.srcb; e.ext = d.ext; e.iord = 1'b1;
                if (d.cls == CL_LW) e.mr = 1'b1;
                else                e.mw = 1'b1;
                if (d.cls == CL_SW && i == n - 1) e.done = 1'b1;
                step(k, "mem", e, m);
            end
            if (d.cls == CL_SW) return;
        end

        // WB
        zero_v[k] = 1'($urandom);
        rdy_v[k]  = 1'($urandom);
        e = '0;
        e.st = S_W; e.alu = d.alu; e.srcb = d.srcb; e.ext = d.ext;
        e.rw = 1'b1; e.done = 1'b1;
        if (d.cls == CL_LW) begin
            e.wd  = 2'b01;
            e.gpr = 2'b01;
        end else if (d.cls == CL_I) begin
            e.gpr = 2'b01;
        end
        step(k, "wb", e, m);
    endtask

    function automatic logic [11:0] pick_legal(input int idx, input logic [5:0] rnd);
        case (idx)
            0: return {6'h00, 6'h20};  1: return {6'h00, 6'h21};  2: return {6'h00, 6'h22};
            3: return {6'h00, 6'h23};  4: return {6'h00, 6'h24};  5: return {6'h00, 6'h25};
            6: return {6'h00, 6'h27};  7: return {6'h00, 6'h2A};  8: return {6'h00, 6'h2B};
            9: return {6'h08, rnd};   10: return {6'h0A, rnd};   11: return {6'h0C, rnd};
           12: return {6'h0D, rnd};   13: return {6'h0F, rnd};   14: return {6'h23, rnd};
           15: return {6'h2B, rnd};   16: return {6'h04, rnd};   17: return {6'h02, rnd};
            default: return {6'h03, rnd};
        endcase
    endfunction

    task automatic run_random(input int k, input int count);
        logic [11:0] w;
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 3) == 0) w = 12'($urandom);
            else w = pick_legal(int'($urandom_range(0, 18)), 6'($urandom));
            run_instr(k, w[11:6], w[5:0], -1, -1, -1, -1);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            op_v[k] = '0; funct_v[k] = '0; zero_v[k] = 1'b0; rdy_v[k] = 1'b0;
        end
        #1;

        // Fixed latency 2
        do_reset();
        run_instr(0, 6'h00, 6'h20, -1, -1, -1, -1);
        run_random(0, 25);

        // Fixed latency 1: add, beq taken/not taken, jal, illegal
        do_reset();
        run_instr(1, 6'h00, 6'h20, -1, -1, -1, -1);
        run_instr(1, 6'h04, 6'h11, 1, -1, -1, -1);
        run_instr(1, 6'h04, 6'h11, 0, -1, -1, -1);
        run_instr(1, 6'h03, 6'h00, -1, -1, -1, -1);
        run_instr(1, 6'h3F, 6'h00, -1, -1, -1, -1);
        run_instr(1, 6'h00, 6'h00, -1, -1, -1, -1);
        run_random(1, 30);

        // Handshake: lw waits three cycles in MEM
        do_reset();
        run_instr(2, 6'h23, 6'h05, -1, 0, 3, -1);
        run_instr(2, 6'h2B, 6'h05, -1, 2, 1, -1);
        run_random(2, 30);

        // Fixed latency 4: sw aborted by reset mid-MEM, then normal operation
        do_reset();
        run_instr(3, 6'h2B, 6'h00, -1, -1, -1, 2);
        do_reset();
        run_instr(3, 6'h00, 6'h25, -1, -1, -1, -1);
        run_random(3, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
